// File: rtl/scoreboard_pkg.sv
// Shared segment codes, segment decoder and converter state encoding
// for the multiplexed scoreboard display driver.
package scoreboard_pkg;

    localparam logic [7:0] SEG_0     = 8'h7E;
    localparam logic [7:0] SEG_1     = 8'h30;
    localparam logic [7:0] SEG_2     = 8'h6D;
    localparam logic [7:0] SEG_3     = 8'h79;
    localparam logic [7:0] SEG_4     = 8'h33;
    localparam logic [7:0] SEG_5     = 8'h5B;
    localparam logic [7:0] SEG_6     = 8'h5F;
    localparam logic [7:0] SEG_7     = 8'h70;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h7B;
    localparam logic [7:0] SEG_DASH  = 8'h01;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_STORE = 2'd2
    } conv_state_e;

    // Non-decimal nibbles cannot come out of the converter; show a dash if one does.
    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter: one LOAD cycle,
// FIELD_W SHIFT cycles, one STORE cycle with done high and bcd final.
module bin2bcd_seq
    import scoreboard_pkg::*;
#(
    parameter int FIELD_W    = 8,
    parameter int BCD_DIGITS = 3
) (
    input  logic                      clk_scan,
    input  logic                      rst,
    input  logic                      start,
    input  logic [FIELD_W-1:0]        bin,
    output logic                      busy,
    output logic                      done,
    output logic [4*BCD_DIGITS-1:0]   bcd
);

    localparam int CNT_W = (FIELD_W > 1) ? $clog2(FIELD_W) : 1;

    conv_state_e               state_r;
    logic [FIELD_W-1:0]        bin_r;
    logic [4*BCD_DIGITS-1:0]   bcd_r;
    logic [4*BCD_DIGITS-1:0]   adj_s;
    logic [CNT_W-1:0]          cnt_r;
    logic                      busy_r;
    logic                      done_r;

    // Add-3 correction applied to every nibble before each shift.
    always_comb begin
        adj_s = bcd_r;
        for (int k = 0; k < BCD_DIGITS; k++) begin
            adj_s[4*k +: 4] = (bcd_r[4*k +: 4] >= 4'd5) ? (bcd_r[4*k +: 4] + 4'd3) : bcd_r[4*k +: 4];
        end
    end

    // Converter FSM with registered busy/done flags.
    always_ff @(posedge clk_scan or posedge rst) begin
        if (rst) begin
            state_r <= ST_LOAD;
            bin_r   <= '0;
            bcd_r   <= '0;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    done_r <= 1'b0;
                    if (start) begin
                        bin_r   <= bin;
                        bcd_r   <= '0;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= ST_SHIFT;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    bcd_r <= {adj_s[4*BCD_DIGITS-2:0], bin_r[FIELD_W-1]};
                    bin_r <= {bin_r[FIELD_W-2:0], 1'b0};
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_r == CNT_W'(FIELD_W-1)) begin
                        state_r <= ST_STORE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_STORE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_LOAD;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_LOAD;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign bcd  = bcd_r;

endmodule

// File: rtl/scoreboard_scan_mux.sv
// Multiplexed 7-segment driver: converts fields to BCD one at a time into a
// shadow store and scans two anode banks with blanking, blink and overflow.
module scoreboard_scan_mux
    import scoreboard_pkg::*;
#(
    parameter int NUM_FIELDS    = 4,
    parameter int FIELD_W       = 8,
    parameter int DIG_PER_FIELD = 2,
    parameter int BLINK_HALF    = 250
) (
    input  logic                                clk_scan,
    input  logic                                rst,
    input  logic [NUM_FIELDS*FIELD_W-1:0]       fields_in,
    input  logic [NUM_FIELDS-1:0]               lz_en,
    input  logic [NUM_FIELDS-1:0]               blink_en,
    input  logic [NUM_FIELDS*DIG_PER_FIELD-1:0] dp,
    output logic [NUM_FIELDS*DIG_PER_FIELD-1:0] an,
    output logic [7:0]                          duan,
    output logic [7:0]                          duan1,
    output logic                                frame_done
);

    localparam int TOTAL      = NUM_FIELDS * DIG_PER_FIELD;
    localparam int HALF       = TOTAL / 2;
    localparam int BCD_DIGITS = (FIELD_W * 301) / 1000 + 1;
    localparam int EXT_D      = (BCD_DIGITS > DIG_PER_FIELD) ? BCD_DIGITS : DIG_PER_FIELD;
    localparam int EXT_W      = 4 * EXT_D;
    localparam int SH_W       = 4 * DIG_PER_FIELD;
    localparam int IDX_W      = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam int SC_W       = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int BK_W       = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [IDX_W-1:0]          idx_r;
    logic [FIELD_W-1:0]        conv_bin_s;
    logic                      conv_start_s;
    logic                      conv_busy_s;
    logic                      conv_done_s;
    logic [4*BCD_DIGITS-1:0]   conv_bcd_s;
    logic [EXT_W-1:0]          bcd_ext_s;
    logic [SH_W-1:0]           low_s;
    logic                      ovf_s;
    logic [SH_W-1:0]           shadow_r [NUM_FIELDS];
    logic [NUM_FIELDS-1:0]     ovf_r;
    logic                      frame_done_r;
    logic [SC_W-1:0]           scan_cnt_r;
    logic [BK_W-1:0]           blink_cnt_r;
    logic                      blink_phase_r;
    logic [TOTAL-1:0]          dig_on_s;
    logic [7:0]                dig_seg_s [TOTAL];
    logic [TOTAL-1:0]          an_next_s;
    logic [7:0]                duan_next_s;
    logic [7:0]                duan1_next_s;
    logic [TOTAL-1:0]          an_r;
    logic [7:0]                duan_r;
    logic [7:0]                duan1_r;

    assign conv_start_s = ~conv_busy_s;

    bin2bcd_seq #(
        .FIELD_W    (FIELD_W),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_bin2bcd (
        .clk_scan (clk_scan),
        .rst      (rst),
        .start    (conv_start_s),
        .bin      (conv_bin_s),
        .busy     (conv_busy_s),
        .done     (conv_done_s),
        .bcd      (conv_bcd_s)
    );

    // Select the field currently being converted and split the result into shown digits and overflow.
    always_comb begin
        conv_bin_s = '0;
        for (int f = 0; f < NUM_FIELDS; f++) begin
            conv_bin_s = (idx_r == IDX_W'(f)) ? fields_in[f*FIELD_W +: FIELD_W] : conv_bin_s;
        end
        bcd_ext_s = EXT_W'(conv_bcd_s);
        low_s     = bcd_ext_s[SH_W-1:0];
        ovf_s     = |(bcd_ext_s >> SH_W);
    end

    // Shadow store, field index and frame pulse, updated on each converter STORE.
    always_ff @(posedge clk_scan or posedge rst) begin
        if (rst) begin
            idx_r        <= '0;
            ovf_r        <= '0;
            frame_done_r <= 1'b0;
            for (int f = 0; f < NUM_FIELDS; f++) begin
                shadow_r[f] <= '0;
            end
        end else begin
            frame_done_r <= conv_done_s && (idx_r == IDX_W'(NUM_FIELDS-1));
            for (int f = 0; f < NUM_FIELDS; f++) begin
                if (conv_done_s && (idx_r == IDX_W'(f))) begin
                    shadow_r[f] <= low_s;
                    ovf_r[f]    <= ovf_s;
                end else begin
                    shadow_r[f] <= shadow_r[f];
                    ovf_r[f]    <= ovf_r[f];
                end
            end
            if (conv_done_s) begin
                idx_r <= (idx_r == IDX_W'(NUM_FIELDS-1)) ? '0 : (idx_r + {{(IDX_W-1){1'b0}}, 1'b1});
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    // Per-digit visibility and segments: blink beats overflow beats leading-zero blanking.
    always_comb begin
        dig_on_s = '0;
        for (int d = 0; d < TOTAL; d++) begin
            dig_seg_s[d] = SEG_BLANK;
            if (blink_en[d / DIG_PER_FIELD] && blink_phase_r) begin
                dig_on_s[d]  = 1'b0;
                dig_seg_s[d] = SEG_BLANK;
            end else if (ovf_r[d / DIG_PER_FIELD]) begin
                dig_on_s[d]  = 1'b1;
                dig_seg_s[d] = SEG_DASH | {dp[d], 7'b0000000};
            end else if (lz_en[d / DIG_PER_FIELD] && ((d % DIG_PER_FIELD) != 0) &&
                         ((shadow_r[d / DIG_PER_FIELD] >> (4 * (d % DIG_PER_FIELD))) == '0)) begin
                dig_on_s[d]  = 1'b0;
                dig_seg_s[d] = SEG_BLANK;
            end else begin
                dig_on_s[d]  = 1'b1;
                dig_seg_s[d] = seg_decode(shadow_r[d / DIG_PER_FIELD][4*(d % DIG_PER_FIELD) +: 4])
                               | {dp[d], 7'b0000000};
            end
        end
    end

    // Pick the right-bank digit p and left-bank digit HALF+p for the current scan position.
    always_comb begin
        an_next_s    = '0;
        duan_next_s  = SEG_BLANK;
        duan1_next_s = SEG_BLANK;
        for (int p = 0; p < HALF; p++) begin
            if (scan_cnt_r == SC_W'(p)) begin
                an_next_s[p]      = dig_on_s[p];
                an_next_s[HALF+p] = dig_on_s[HALF+p];
                duan_next_s       = dig_seg_s[p];
                duan1_next_s      = dig_seg_s[HALF+p];
            end else begin
                duan_next_s       = duan_next_s;
            end
        end
    end

    // Scan position, global blink timebase and registered display outputs.
    always_ff @(posedge clk_scan or posedge rst) begin
        if (rst) begin
            scan_cnt_r    <= '0;
            blink_cnt_r   <= '0;
            blink_phase_r <= 1'b0;
            an_r          <= '0;
            duan_r        <= 8'h00;
            duan1_r       <= 8'h00;
        end else begin
            scan_cnt_r <= (scan_cnt_r == SC_W'(HALF-1)) ? '0 : (scan_cnt_r + {{(SC_W-1){1'b0}}, 1'b1});
            if (blink_cnt_r == BK_W'(BLINK_HALF-1)) begin
                blink_cnt_r   <= '0;
                blink_phase_r <= ~blink_phase_r;
            end else begin
                blink_cnt_r   <= blink_cnt_r + {{(BK_W-1){1'b0}}, 1'b1};
            end
            an_r    <= an_next_s;
            duan_r  <= duan_next_s;
            duan1_r <= duan1_next_s;
        end
    end

    assign an         = an_r;
    assign duan       = duan_r;
    assign duan1      = duan1_r;
    assign frame_done = frame_done_r;

endmodule
